// File: rtl/gb_cpu_common_pkg.sv
// ---------------------------------------------------------------------------
// gb_cpu_common_pkg
// Shared types and constants for the CPU front end (fetch, PC, decoder).
//   fetch_state_t     - states of the opcode fetch engine
//   CB_PREFIX_OPCODE  - the prefix byte that selects the extended opcode table
//   pc_increment()    - 16-bit program counter step, wrapping FFFF -> 0000
// ---------------------------------------------------------------------------
package gb_cpu_common_pkg;

    typedef enum logic [2:0] {
        FETCH_OP,
        WAIT_OP,
        FETCH_CB,
        WAIT_CB,
        HOLD,
        DRAIN
    } fetch_state_t;

    localparam logic [7:0] CB_PREFIX_OPCODE = 8'hCB;

    // The address space is exactly 16 bits, so the carry out is simply lost.
    function automatic logic [15:0] pc_increment(input logic [15:0] cur_pc);
        return cur_pc + 16'd1;
    endfunction

endpackage

// File: rtl/gb_cpu_pc_reg.sv
// ---------------------------------------------------------------------------
// gb_cpu_pc_reg
// 16-bit program counter with load, increment and hold.
// Ports:
//   clk       - system clock
//   reset     - synchronous active-high reset, loads RESET_PC
//   load      - take load_val this cycle (wins over inc)
//   load_val  - redirect target
//   inc       - advance by one, wrapping FFFF -> 0000
//   pc        - current program counter
// ---------------------------------------------------------------------------
module gb_cpu_pc_reg
    import gb_cpu_common_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        inc,
    output logic [15:0] pc
);

    // A redirect always beats the increment so a jump issued while a byte is
    // being requested lands exactly on its target rather than target+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc_increment(pc);
        end
    end

endmodule

// File: rtl/gb_cpu_fetch.sv
// ---------------------------------------------------------------------------
// gb_cpu_fetch
// Opcode fetch engine: owns the PC, issues byte reads, folds the 0xCB prefix
// into a single {opcode, cb_prefix} hand-off to the decoder/sequencer.
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   mem_req, mem_addr     - one-cycle read request and its byte address
//   mem_valid, mem_rdata  - read data return (at least one cycle later)
//   op_valid, op_ready    - opcode hand-off handshake
//   opcode, cb_prefix     - fetched opcode and its table select
//   pc                    - address of the next byte to fetch
//   pc_load, pc_load_val  - redirect (jump/call/interrupt), flushes the fetch
// Build option GB_CPU_HALT_BUG_EN adds input halt_bug: a pulse makes the next
// opcode fetch leave the PC alone, so the same byte is fetched twice.
// ---------------------------------------------------------------------------
module gb_cpu_fetch
    import gb_cpu_common_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_valid,
    input  logic [7:0]  mem_rdata,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [7:0]  opcode,
    output logic        cb_prefix,
    output logic [15:0] pc,
    input  logic        pc_load,
`ifdef GB_CPU_HALT_BUG_EN
    input  logic        halt_bug,
`endif
    input  logic [15:0] pc_load_val
);

    fetch_state_t state, state_d;
    logic         op_valid_d;
    logic [7:0]   opcode_d;
    logic         cb_prefix_d;
    logic         drop, drop_d;
    logic         pc_inc;
    logic         halt_hold;
    logic         fetching;

    gb_cpu_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    // The request is a direct decode of the fetch states, so a byte can be
    // requested in the very cycle the engine arrives there; this is what keeps
    // the CB second byte to two extra cycles. Held low while in reset.
    assign fetching = (state == FETCH_OP) || (state == FETCH_CB);
    assign mem_req  = fetching && !reset;
    assign mem_addr = mem_req ? pc : 16'h0000;

`ifdef GB_CPU_HALT_BUG_EN
    logic halt_armed;

    // Armed by the halt bug pulse and consumed by the next opcode fetch. A
    // redirect cancels it because the repeated byte would no longer be the
    // one after the HALT.
    always_ff @(posedge clk) begin
        if (reset) begin
            halt_armed <= 1'b0;
        end else if (pc_load) begin
            halt_armed <= 1'b0;
        end else if (halt_bug) begin
            halt_armed <= 1'b1;
        end else if (state == FETCH_OP) begin
            halt_armed <= 1'b0;
        end
    end

    assign halt_hold = halt_armed;
`else
    assign halt_hold = 1'b0;
`endif

    // Next-state and output-register logic. The normal walk is
    // FETCH_OP -> WAIT_OP -> (FETCH_CB -> WAIT_CB) -> HOLD -> FETCH_OP.
    // A redirect overrides everything afterwards: if a read is still in
    // flight we must swallow its answer in DRAIN, otherwise we restart
    // fetching at the new PC straight away. Note the FETCH_* states count as
    // "in flight" because their request goes out in the same cycle.
    always_comb begin
        state_d     = state;
        op_valid_d  = op_valid;
        opcode_d    = opcode;
        cb_prefix_d = cb_prefix;
        drop_d      = drop;
        pc_inc      = 1'b0;

        case (state)
            FETCH_OP: begin
                pc_inc  = !halt_hold;
                state_d = WAIT_OP;
            end
            WAIT_OP: begin
                if (mem_valid) begin
                    if (mem_rdata == CB_PREFIX_OPCODE) begin
                        state_d = FETCH_CB;
                    end else begin
                        opcode_d    = mem_rdata;
                        cb_prefix_d = 1'b0;
                        op_valid_d  = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            FETCH_CB: begin
                pc_inc  = 1'b1;
                state_d = WAIT_CB;
            end
            WAIT_CB: begin
                if (mem_valid) begin
                    opcode_d    = mem_rdata;
                    cb_prefix_d = 1'b1;
                    op_valid_d  = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (op_valid && op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = FETCH_OP;
                end
            end
            DRAIN: begin
                if (drop && mem_valid) begin
                    drop_d  = 1'b0;
                    state_d = FETCH_OP;
                end
            end
            default: begin
                state_d = FETCH_OP;
            end
        endcase

        if (pc_load) begin
            op_valid_d  = 1'b0;
            cb_prefix_d = 1'b0;
            opcode_d    = opcode;
            pc_inc      = 1'b0;
            if (fetching ||
                (((state == WAIT_OP) || (state == WAIT_CB) || (state == DRAIN)) && !mem_valid)) begin
                drop_d  = 1'b1;
                state_d = DRAIN;
            end else begin
                drop_d  = 1'b0;
                state_d = FETCH_OP;
            end
        end
    end

    // State and the decoder-facing registers all update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH_OP;
            op_valid  <= 1'b0;
            opcode    <= 8'h00;
            cb_prefix <= 1'b0;
            drop      <= 1'b0;
        end else begin
            state     <= state_d;
            op_valid  <= op_valid_d;
            opcode    <= opcode_d;
            cb_prefix <= cb_prefix_d;
            drop      <= drop_d;
        end
    end

endmodule
